// File: rtl/ret_stack_ctrl.sv
// Return-address stack for the next-PC path: pushes call_pc+4 on CALL, exposes the
// top entry combinationally and pops it on RET; overflow/underflow freeze the stack.
module ret_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             stall,
    input  logic [18:0]      call_pc,
    input  logic             err_clr,
    output logic [18:0]      stk_ret_inst,
    output logic [PTR_W:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic [PTR_W:0] SP_MAX = (PTR_W+1)'(DEPTH);

    state_t         state;
    logic [PTR_W:0] sp;
    logic [18:0]    mem [DEPTH];

    logic           push;
    logic           pop;
    logic [PTR_W:0] sp_inc;
    logic [PTR_W:0] sp_dec;
    logic [18:0]    push_val;

    // CALL wins over RET, matching the PC select priority
    assign push     = call_en & ~stall;
    assign pop      = ret_en & ~call_en & ~stall;
    assign sp_inc   = sp + 1'b1;
    assign sp_dec   = sp - 1'b1;
    assign push_val = call_pc + 19'd4;

    assign depth        = sp;
    assign empty        = (sp == '0);
    assign full         = (sp == SP_MAX);
    assign stk_ret_inst = (sp != '0) ? mem[sp_dec[PTR_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst && push && (state == S_EMPTY || state == S_PARTIAL)) begin
            mem[sp[PTR_W-1:0]] <= push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_EMPTY;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        sp    <= sp_inc;
                        state <= (sp_inc == SP_MAX) ? S_FULL : S_PARTIAL;
                    end else if (pop) begin
                        underflow <= 1'b1;
                        state     <= S_ERROR;
                    end
                end
                S_PARTIAL: begin
                    if (push) begin
                        sp    <= sp_inc;
                        state <= (sp_inc == SP_MAX) ? S_FULL : S_PARTIAL;
                    end else if (pop) begin
                        sp    <= sp_dec;
                        state <= (sp_dec == '0) ? S_EMPTY : S_PARTIAL;
                    end
                end
                S_FULL: begin
                    if (push) begin
                        overflow <= 1'b1;
                        state    <= S_ERROR;
                    end else if (pop) begin
                        sp    <= sp_dec;
                        state <= (sp_dec == '0) ? S_EMPTY : S_PARTIAL;
                    end
                end
                S_ERROR: begin
                    // sp is frozen here, so the exit state is recovered from it
                    if (err_clr) begin
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        if (sp == '0)
                            state <= S_EMPTY;
                        else if (sp == SP_MAX)
                            state <= S_FULL;
                        else
                            state <= S_PARTIAL;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/ret_stack_ctrl.md
# ret_stack_ctrl

Return-address stack controller for the 19-bit processor's next-PC path. On every CALL it pushes the caller's return address (call PC + 4). It presents the top entry combinationally on `stk_ret_inst`, which feeds the PC adder's return selection, and pops that entry on RET. It also reports stack depth and full/empty status, and latches overflow/underflow errors that freeze the stack until cleared.

## Interface
Parameters:
- `DEPTH`, 8: number of stack entries; power of two, 2..64.
- `PTR_W`, 3: log2(`DEPTH`); pointer width.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `call_en`, input, 1: current instruction is CALL; push request.
- `ret_en`, input, 1: current instruction is RET; pop request.
- `stall`, input, 1: pipeline stall; while 1, push and pop are suppressed.
- `call_pc`, input, 19: PC of the CALL instruction.
- `err_clr`, input, 1: clears sticky errors and leaves ERROR state.
- `stk_ret_inst`, output, 19: return address at the top of the stack; 0 when empty.
- `depth`, output, `PTR_W`+1: current number of valid entries.
- `empty`, output, 1: `depth` == 0.
- `full`, output, 1: `depth` == `DEPTH`.
- `overflow`, output, 1: sticky; set by a push attempted while full.
- `underflow`, output, 1: sticky; set by a pop attempted while empty.

## Operation
- Storage is a `DEPTH` x 19 register array plus a pointer `sp` of width `PTR_W`+1.
- `depth` equals `sp`. The top entry is `mem[sp-1]`.
- Effective operations, with call taking priority as in the PC select:
  - push = `call_en` & ~`stall`.
  - pop = `ret_en` & ~`call_en` & ~`stall`.
- `call_en` and `ret_en` high in the same cycle is a push only; `ret_en` is ignored.
- Push value = `call_pc` + 19'd4, truncated to 19 bits. 19'h7FFFC + 4 wraps to 19'h00000.
- State machine:
  - EMPTY (`sp` == 0):
    - push: write `mem[0]`, `sp` = 1, go to PARTIAL (or FULL if `DEPTH` == 1).
    - pop: set `underflow`, go to ERROR.
  - PARTIAL (0 < `sp` < `DEPTH`):
    - push: write `mem[sp]`, `sp`+1; go to FULL when `sp`+1 == `DEPTH`.
    - pop: `sp`-1; go to EMPTY when `sp`-1 == 0.
  - FULL (`sp` == `DEPTH`):
    - pop: `sp`-1, go to PARTIAL.
    - push: set `overflow`, go to ERROR. Contents and `sp` are unchanged.
  - ERROR:
    - All pushes and pops are ignored; `sp` and contents are frozen.
    - `stk_ret_inst` shows the frozen top.
    - `err_clr` = 1: clear `overflow` and `underflow`, then return to EMPTY, PARTIAL or FULL according to `sp`.
    - A push or pop in the same cycle as `err_clr` is ignored.
- `err_clr` outside ERROR has no effect.
- `stk_ret_inst` = `mem[sp-1]` when `sp` > 0, else 19'd0. It is purely combinational from registered state.

## Timing
- Reset (`rst` = 0 at a rising edge):
  - `sp` = 0, state = EMPTY.
  - `overflow` = 0, `underflow` = 0.
  - `stk_ret_inst` = 0, `depth` = 0, `empty` = 1, `full` = 0.
  - Array contents are don't-care.
- Reset dominates every other input. Asserting `rst` mid-sequence discards all entries on that edge.
- Push latency: the value written at edge N appears on `stk_ret_inst` and in `depth` after edge N, i.e. in cycle N+1.
- Pop:
  - In the RET cycle, `stk_ret_inst` already holds the return address, so the PC adder uses it that same cycle.
  - The entry is removed at the following edge; the next entry is visible one cycle later.
- Back-to-back operations:
  - CALL in cycle N followed by RET in cycle N+1 returns `call_pc`(N) + 4 in cycle N+1.
  - Push and pop on consecutive cycles are sustained indefinitely, with no bubbles.
- `overflow` and `underflow` rise one cycle after the offending request and hold until the edge that samples `err_clr` = 1.
- While `stall` = 1:
  - All state holds.
  - Sticky flags are not set by stalled requests.
  - `stk_ret_inst` is stable.

## Test plan
- Reset, then a single call:
  - After reset, `empty` = 1, `stk_ret_inst` = 0.
  - CALL with `call_pc` = 19'h00100 → next cycle `stk_ret_inst` = 19'h00104, `depth` = 1.
  - RET → `stk_ret_inst` = 19'h00104 during the RET cycle; next cycle `depth` = 0, `empty` = 1.
- Nested calls (`DEPTH` = 8):
  - Push `call_pc` = 0x10, 0x20, ..., 0x80 → `full` = 1.
  - Eight RETs present 0x84, 0x74, ..., 0x14 in order, then `empty` = 1.
- Overflow:
  - With the stack full, CALL `call_pc` = 0x200 → `overflow` = 1 next cycle, `depth` stays 8, top stays 0x84.
  - Further RETs are ignored.
  - `err_clr` → `overflow` = 0, state back to FULL.
- Underflow:
  - RET on an empty stack → `underflow` = 1, `stk_ret_inst` = 0.
  - `err_clr` → `underflow` = 0, EMPTY.
- Priority, stall and wrap:
  - `call_en` = `ret_en` = 1 with `call_pc` = 0x40 → push only, `depth` +1, top 0x44.
  - CALL with `stall` = 1 → no change.
  - CALL with `call_pc` = 19'h7FFFC → top = 19'h00000.
- Reset mid-operation:
  - Push 3 entries, assert `rst` for one cycle → `depth` = 0, `empty` = 1, flags 0.
  - A subsequent CALL with `call_pc` = 0x8 → top = 0xC.
